// File: rtl/dram_arbiter.sv
// dram_arbiter: two-master round-robin arbiter and sequencer for the data RAM port.
// Master 0 is the core memory stage, master 1 a secondary bus master. The winner's
// command is latched, issued to the RAM for one cycle, the read latency is waited
// out, and a one-cycle ack is returned to the granted master.
module dram_arbiter #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,

    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,

    output logic        ram_ce_o,
    output logic        ram_we_o,
    output logic [3:0]  ram_sel_o,
    output logic [31:0] ram_addr_o,
    output logic [31:0] ram_data_o,
    input  logic [31:0] ram_data_i,

    output logic        stall_req_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // Counter start value: WAIT lasts RD_LAT cycles, counting down to zero.
    localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

    state_t      state_q, state_d;
    logic        grant_q, grant_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic        latch_cmd;
    logic        capture;

    logic        cmd_we_q;
    logic [3:0]  cmd_sel_q;
    logic [31:0] cmd_addr_q;
    logic [31:0] cmd_wdata_q;

    logic        win_we;
    logic [3:0]  win_sel;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;

    // Next-state logic: round-robin grant in IDLE, latency countdown in WAIT.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        lat_cnt_d    = lat_cnt_q;
        latch_cmd    = 1'b0;
        capture      = 1'b0;
        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    if (m0_req && m1_req) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = m1_req;
                    end
                    last_grant_d = grant_d;
                    latch_cmd    = 1'b1;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (cmd_we_q) begin
                    state_d = RESP;
                end else begin
                    lat_cnt_d = LAT_INIT;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt_q != 2'd0) begin
                    lat_cnt_d = lat_cnt_q - 2'd1;
                end else begin
                    capture = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Select the command of the master being granted this cycle.
    always_comb begin
        win_we    = m0_we;
        win_sel   = m0_sel;
        win_addr  = m0_addr;
        win_wdata = m0_wdata;
        if (grant_d) begin
            win_we    = m1_we;
            win_sel   = m1_sel;
            win_addr  = m1_addr;
            win_wdata = m1_wdata;
        end
    end

    // Control registers; last_grant resets to 1 so master 0 wins the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            lat_cnt_q    <= 2'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            lat_cnt_q    <= lat_cnt_d;
        end
    end

    // Command latch: captures the winner's command at the grant edge and holds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_we_q    <= 1'b0;
            cmd_sel_q   <= 4'd0;
            cmd_addr_q  <= 32'd0;
            cmd_wdata_q <= 32'd0;
        end else if (latch_cmd) begin
            cmd_we_q    <= win_we;
            cmd_sel_q   <= win_sel;
            cmd_addr_q  <= win_addr;
            cmd_wdata_q <= win_wdata;
        end
    end

    // Read data registers: only the granted master's copy updates, and only on a read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m0_rdata <= 32'd0;
            m1_rdata <= 32'd0;
        end else if (capture) begin
            if (grant_q) begin
                m1_rdata <= ram_data_i;
            end else begin
                m0_rdata <= ram_data_i;
            end
        end
    end

    // RAM port is driven from the latched command only during ISSUE, zero otherwise.
    always_comb begin
        ram_ce_o   = 1'b0;
        ram_we_o   = 1'b0;
        ram_sel_o  = 4'd0;
        ram_addr_o = 32'd0;
        ram_data_o = 32'd0;
        if (state_q == ISSUE) begin
            ram_ce_o   = 1'b1;
            ram_we_o   = cmd_we_q;
            ram_sel_o  = cmd_sel_q;
            ram_addr_o = cmd_addr_q;
            ram_data_o = cmd_wdata_q;
        end
    end

    // Acks come straight from the RESP state and the grant register.
    always_comb begin
        m0_ack      = (state_q == RESP) && !grant_q;
        m1_ack      = (state_q == RESP) &&  grant_q;
        stall_req_o = m0_req & ~m0_ack;
    end

endmodule
